score_display_ctrl: RTL and testbench
=====================================

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles per digit-select phase (range >= 2).
REQ-002 Parameter HOLD_CYCLES, default 25000000, point-freeze duration in clock cycles (range >= 1).
REQ-003 Parameter WIN_SCORE, default 9, score that ends the game (range 1..9).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 point_p0  input  1  one-cycle pulse: player 0 scored.
REQ-007 point_p1  input  1  one-cycle pulse: player 1 scored.
REQ-008 clear  input  1  synchronous new-game request, level-sampled.
REQ-009 num_0  output  4  player 0 score, BCD 0..9, to the digit driver.
REQ-010 num_1  output  4  player 1 score, BCD 0..9, to the digit driver.
REQ-011 count  output  1  digit select: 0 shows num_0, 1 shows num_1.
REQ-012 game_over  output  1  high while in state OVER.
REQ-013 winner  output  1  0 = player 0 won, 1 = player 1 won; valid only when game_over=1.

Function
REQ-014 Refresh counter runs 0..REFRESH_DIV-1 and wraps in every state; count toggles on the cycle the counter equals REFRESH_DIV-1.
REQ-015 FSM has states PLAY, HOLD and OVER; reset state is PLAY.
REQ-016 PLAY + point_p0: num_0 increments by 1; go to OVER if the new value equals WIN_SCORE, otherwise go to HOLD.
REQ-017 PLAY + point_p1 (point_p0 low): same rule for num_1.
REQ-018 point_p0 and point_p1 high in the same cycle: only point_p0 is counted; point_p1 is dropped.
REQ-019 HOLD: a counter loads HOLD_CYCLES-1 on entry and decrements; state returns to PLAY the cycle after it reaches 0; all point pulses are ignored in HOLD.
REQ-020 OVER: point pulses are ignored; scores, winner and game_over stay frozen.
REQ-021 clear=1 in any state: next cycle num_0=num_1=0, state=PLAY, hold counter=0; clear takes priority over same-cycle point pulses.
REQ-022 Scores never exceed WIN_SCORE and never wrap; a score increment and the resulting state change take effect on the same edge (1-cycle latency from pulse to num_x).
REQ-023 winner is latched on entry to OVER and is 0 at all other times.
REQ-024 The refresh counter and count are unaffected by clear and by FSM state.

Reset
REQ-025 rst_n low asynchronously forces num_0=0, num_1=0, count=0, game_over=0, winner=0, state=PLAY, refresh and hold counters to 0.
REQ-026 Reset asserted mid-HOLD or in OVER aborts the operation with no residual state; the first rising edge after rst_n deasserts behaves as PLAY.

Configuration
REQ-027 Macro SCORE_BLINK_EN: when defined, the module adds output blank (1 bit) and a blink phase bit that toggles every 64 count toggles.
REQ-028 With SCORE_BLINK_EN defined, blank=1 only when game_over=1, blink phase=1, and count selects the winner's digit; otherwise blank=0; blank resets to 0 and the blink phase resets to 0.
REQ-029 Without SCORE_BLINK_EN, no blank port or blink logic exists, and all other behaviour is identical.

Verification (bench parameters: REFRESH_DIV=4, HOLD_CYCLES=8, WIN_SCORE=3)
REQ-030 After reset, run free for 16 cycles -> count toggles every 4 cycles (0,1,0,1), and num_0=num_1=0 throughout.
REQ-031 point_p0 pulse in PLAY -> num_0=1 next cycle; a point_p1 pulse 3 cycles later is ignored (num_1=0); PLAY resumes 8 cycles after entry to HOLD.
REQ-032 point_p0 and point_p1 in the same PLAY cycle -> num_0=1, num_1=0, state HOLD.
REQ-033 Three player 1 points, each separated by a full hold -> num_1=3, game_over=1, winner=1; further pulses leave the scores 0/3; clear -> 0/0, game_over=0 next cycle.
REQ-034 rst_n pulled low mid-HOLD with score 2/1 -> all outputs 0 immediately, before any clock edge; after release, a point_p1 pulse is counted on the first cycle.
REQ-035 With SCORE_BLINK_EN defined, in OVER with winner=0 -> blank high only during count=0 phases of every other 64-toggle blink window.

Source files
------------

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: two-player score keeper with point freeze, game-over latch and digit-select refresh.
// Define SCORE_BLINK_EN to add the blank output that blinks the winner's digit in OVER.
module score_display_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       point_p0,
  input  logic       point_p1,
  input  logic       clear,
  output logic [3:0] num_0,
  output logic [3:0] num_1,
  output logic       count,
  output logic       game_over,
  output logic       winner
`ifdef SCORE_BLINK_EN
  ,
  output logic       blank
`endif
);
  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

  state_t        state;
  logic [RW-1:0] ref_cnt;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    nxt_0, nxt_1;
  logic          ref_wrap;

  assign nxt_0    = num_0 + 4'd1;
  assign nxt_1    = num_1 + 4'd1;
  assign ref_wrap = (ref_cnt == REF_LAST);

  // Refresh runs independently of the game and ignores clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ref_cnt <= '0;
      count   <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      count   <= ref_wrap ? ~count : count;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= PLAY;
      num_0     <= '0;
      num_1     <= '0;
      hold_cnt  <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (clear) begin
      state     <= PLAY;
      num_0     <= '0;
      num_1     <= '0;
      hold_cnt  <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      case (state)
        PLAY:
          if (point_p0) begin
            num_0 <= nxt_0;
            if (nxt_0 == WIN) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end else if (point_p1) begin
            num_1 <= nxt_1;
            if (nxt_1 == WIN) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end
        HOLD:
          if (hold_cnt == '0) state <= PLAY;
          else hold_cnt <= hold_cnt - 1'b1;
        OVER: state <= OVER;
        default: state <= PLAY;
      endcase
    end

`ifdef SCORE_BLINK_EN
  logic [5:0] blink_cnt;
  logic       blink_phase;

  // Phase flips once every 64 digit-select toggles.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (ref_wrap) begin
      blink_cnt   <= blink_cnt + 6'd1;
      blink_phase <= (blink_cnt == 6'd63) ? ~blink_phase : blink_phase;
    end

  assign blank = game_over & blink_phase & (count == winner);
`endif
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed checks of scoring, hold, game-over, clear and async reset.
module tb_score_display_ctrl;
  localparam int RD = 4;
  localparam int HC = 8;
  localparam int WS = 3;

  logic       clk = 0, rst_n = 0, point_p0 = 0, point_p1 = 0, clear = 0;
  logic [3:0] num_0, num_1;
  logic       count, game_over, winner;
`ifdef SCORE_BLINK_EN
  logic       blank;
`endif
  int vectors = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  // Edges seen since reset release, used to predict count and blink phase.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  score_display_ctrl #(.REFRESH_DIV(RD), .HOLD_CYCLES(HC), .WIN_SCORE(WS)) dut (
    .clk(clk), .rst_n(rst_n), .point_p0(point_p0), .point_p1(point_p1), .clear(clear),
    .num_0(num_0), .num_1(num_1), .count(count), .game_over(game_over), .winner(winner)
`ifdef SCORE_BLINK_EN
    , .blank(blank)
`endif
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic a, input logic b);
    point_p0 = a;
    point_p1 = b;
    tick();
    point_p0 = 0;
    point_p1 = 0;
  endtask

  task automatic do_clear;
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({num_0, num_1, count, game_over, winner} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d c=%b go=%b w=%b expected all 0", num_0, num_1, count, game_over, winner);
    end
    rst_n = 1;
  endtask

  task automatic test_refresh;
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++;
      if (count !== 1'((k / 4) % 2) || num_0 !== 4'd0 || num_1 !== 4'd0) begin
        errors++;
        $display("FAIL refresh k=%0d count=%b expected %0d nums=%0d/%0d expected 0/0", k, count, (k / 4) % 2, num_0, num_1);
      end
    end
  endtask

  task automatic test_point_p0;
    pulse(1, 0);
    vectors++;
    if (num_0 !== 4'd1 || num_1 !== 4'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL p0_incr got %0d/%0d go=%b expected 1/0 go=0", num_0, num_1, game_over);
    end
    tick(2);
    pulse(0, 1);
    vectors++;
    if (num_1 !== 4'd0) begin
      errors++;
      $display("FAIL hold_ignore num_1=%0d expected 0", num_1);
    end
    tick(4);
    pulse(0, 1);
    vectors++;
    if (num_1 !== 4'd0) begin
      errors++;
      $display("FAIL hold_last_cycle num_1=%0d expected 0", num_1);
    end
    pulse(0, 1);
    vectors++;
    if (num_1 !== 4'd1) begin
      errors++;
      $display("FAIL play_resume num_1=%0d expected 1", num_1);
    end
    do_clear();
    vectors++;
    if (num_0 !== 4'd0 || num_1 !== 4'd0) begin
      errors++;
      $display("FAIL clear_in_hold got %0d/%0d expected 0/0", num_0, num_1);
    end
  endtask

  task automatic test_simultaneous;
    pulse(1, 1);
    vectors++;
    if (num_0 !== 4'd1 || num_1 !== 4'd0) begin
      errors++;
      $display("FAIL simultaneous got %0d/%0d expected 1/0", num_0, num_1);
    end
    pulse(1, 0);
    vectors++;
    if (num_0 !== 4'd1) begin
      errors++;
      $display("FAIL simultaneous_hold num_0=%0d expected 1", num_0);
    end
    do_clear();
  endtask

  task automatic test_win_p1;
    for (int i = 0; i < WS; i++) begin
      pulse(0, 1);
      vectors++;
      if (num_1 !== 4'(i + 1)) begin
        errors++;
        $display("FAIL win_p1_step%0d num_1=%0d expected %0d", i, num_1, i + 1);
      end
      if (i < WS - 1) tick(HC);
    end
    vectors++;
    if (game_over !== 1'b1 || winner !== 1'b1 || num_0 !== 4'd0) begin
      errors++;
      $display("FAIL win_p1_over go=%b w=%b num_0=%0d expected go=1 w=1 num_0=0", game_over, winner, num_0);
    end
    pulse(1, 0);
    pulse(0, 1);
    tick(10);
    pulse(1, 1);
    vectors++;
    if (num_0 !== 4'd0 || num_1 !== 4'd3 || game_over !== 1'b1 || winner !== 1'b1) begin
      errors++;
      $display("FAIL over_frozen got %0d/%0d go=%b w=%b expected 0/3 go=1 w=1", num_0, num_1, game_over, winner);
    end
    clear = 1;
    point_p0 = 1;
    tick();
    clear = 0;
    point_p0 = 0;
    vectors++;
    if (num_0 !== 4'd0 || num_1 !== 4'd0 || game_over !== 1'b0 || winner !== 1'b0) begin
      errors++;
      $display("FAIL clear_over got %0d/%0d go=%b w=%b expected 0/0 go=0 w=0", num_0, num_1, game_over, winner);
    end
  endtask

  task automatic test_reset_mid_hold;
    pulse(1, 0);
    tick(HC);
    pulse(1, 0);
    tick(HC);
    pulse(0, 1);
    tick(2);
    vectors++;
    if (num_0 !== 4'd2 || num_1 !== 4'd1) begin
      errors++;
      $display("FAIL pre_reset_score got %0d/%0d expected 2/1", num_0, num_1);
    end
    rst_n = 0;
    #1;
    vectors++;
    if ({num_0, num_1, count, game_over, winner} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset got %0d/%0d c=%b go=%b w=%b expected all 0", num_0, num_1, count, game_over, winner);
    end
    #3;
    rst_n = 1;
    pulse(0, 1);
    vectors++;
    if (num_1 !== 4'd1 || num_0 !== 4'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_point got %0d/%0d go=%b expected 0/1 go=0", num_0, num_1, game_over);
    end
  endtask

  task automatic test_win_p0;
    do_clear();
    for (int i = 0; i < WS; i++) begin
      pulse(1, 0);
      if (i < WS - 1) tick(HC);
    end
    vectors++;
    if (num_0 !== 4'd3 || num_1 !== 4'd0 || game_over !== 1'b1 || winner !== 1'b0) begin
      errors++;
      $display("FAIL win_p0 got %0d/%0d go=%b w=%b expected 3/0 go=1 w=0", num_0, num_1, game_over, winner);
    end
`ifdef SCORE_BLINK_EN
    for (int k = 0; k < 600; k++) begin
      tick();
      vectors++;
      if (blank !== (((cyc / 256) % 2 == 1) && ((cyc / 4) % 2 == 0))) begin
        errors++;
        $display("FAIL blink cyc=%0d blank=%b count=%b", cyc, blank, count);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_refresh();
    test_point_p0();
    test_simultaneous();
    test_win_p1();
    test_reset_mid_hold();
    test_win_p0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
